// File: rtl/dff_bank_arbiter_if.sv
// ---------------------------------------------------------------------------
// dff_bank_arbiter_if
// Bundles the requester-side bus of the shared-register arbiter.
//
//   req      NREQ        per-requester request, held until matching ack
//   op       2*NREQ      per-requester opcode, requester i at [2i+1:2i]
//                        00 load, 01 set, 10 clear, 11 toggle
//   din      WIDTH*NREQ  per-requester load data, requester i at [WIDTH*i +: WIDTH]
//   gnt      NREQ        one-hot registered grant
//   ack      NREQ        one-hot, one-cycle registered commit acknowledge
//   out      WIDTH       shared register value
//   out_bar  WIDTH       bitwise inverse of out
//   busy     1           arbiter is mid-transaction
//
// master: the requester side (drives req/op/din)
// slave : the arbiter side (drives gnt/ack/out/out_bar/busy)
// ---------------------------------------------------------------------------
interface dff_bank_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
);
    logic [NREQ-1:0]       req;
    logic [2*NREQ-1:0]     op;
    logic [WIDTH*NREQ-1:0] din;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       ack;
    logic [WIDTH-1:0]      out;
    logic [WIDTH-1:0]      out_bar;
    logic                  busy;

    modport master (
        output req, op, din,
        input  gnt, ack, out, out_bar, busy
    );

    modport slave (
        input  req, op, din,
        output gnt, ack, out, out_bar, busy
    );
endinterface

// File: rtl/dff_bank_arbiter.sv
// ---------------------------------------------------------------------------
// dff_bank_arbiter
// Shares one WIDTH-bit register between NREQ requesters with round-robin
// fairness. Each transaction runs IDLE -> GRANT -> COMMIT: the winner and its
// op/din are captured on the IDLE edge, the op is applied to the register and
// acknowledged on the GRANT edge, and grant/ack are withdrawn on the COMMIT
// edge.
//
// Ports:
//   Clk    input   clock, all state changes on the rising edge
//   Reset  input   synchronous active-low reset
//   bus    slave   req/op/din in, gnt/ack/out/out_bar/busy out
// ---------------------------------------------------------------------------
module dff_bank_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
) (
    input logic               Clk,
    input logic               Reset,
    dff_bank_arbiter_if.slave bus
);

    localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] GRANT  = 2'd1;
    localparam logic [1:0] COMMIT = 2'd2;

    localparam logic [1:0] OP_LOAD   = 2'b00;
    localparam logic [1:0] OP_SET    = 2'b01;
    localparam logic [1:0] OP_CLEAR  = 2'b10;
    localparam logic [1:0] OP_TOGGLE = 2'b11;

    logic [1:0]       r_state;
    logic [IDXW-1:0]  r_rrPtr;
    logic [IDXW-1:0]  r_winner;
    logic [1:0]       r_op;
    logic [WIDTH-1:0] r_din;
    logic [WIDTH-1:0] r_out;
    logic [NREQ-1:0]  r_gnt;
    logic [NREQ-1:0]  r_ack;

    logic             w_anyFound;
    logic             w_aboveFound;
    logic [IDXW-1:0]  w_lowAny;
    logic [IDXW-1:0]  w_lowAbove;
    logic             w_found;
    logic [IDXW-1:0]  w_winner;
    logic [NREQ-1:0]  w_winnerOneHot;
    logic [1:0]       w_winnerOp;
    logic [WIDTH-1:0] w_winnerDin;
    logic [WIDTH-1:0] w_nextOut;

    // Round-robin search without modulo arithmetic: the requester after
    // r_rrPtr in circular order is the lowest requesting index above the
    // pointer, or, if none sits above it, the lowest requesting index overall.
    // Scanning downward lets the last hit be the lowest index.
    always_comb begin
        w_anyFound   = 1'b0;
        w_aboveFound = 1'b0;
        w_lowAny     = '0;
        w_lowAbove   = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (bus.req[i]) begin
                w_anyFound = 1'b1;
                w_lowAny   = IDXW'(i);
                if (IDXW'(i) > r_rrPtr) begin
                    w_aboveFound = 1'b1;
                    w_lowAbove   = IDXW'(i);
                end
            end
        end
        w_found  = w_anyFound;
        w_winner = w_aboveFound ? w_lowAbove : w_lowAny;
    end

    // Steer the winner's opcode and data out of the packed request buses and
    // build its one-hot grant vector.
    always_comb begin
        w_winnerOneHot = '0;
        w_winnerOp     = OP_LOAD;
        w_winnerDin    = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (IDXW'(i) == w_winner) begin
                w_winnerOneHot[i] = 1'b1;
                w_winnerOp        = bus.op[2*i +: 2];
                w_winnerDin       = bus.din[WIDTH*i +: WIDTH];
            end
        end
    end

    // Next register value for the captured operation; always a full-width
    // write, toggle inverts every bit of the current value.
    always_comb begin
        w_nextOut = r_out;
        case (r_op)
            OP_LOAD:   w_nextOut = r_din;
            OP_SET:    w_nextOut = '1;
            OP_CLEAR:  w_nextOut = '0;
            OP_TOGGLE: w_nextOut = ~r_out;
            default:   w_nextOut = r_out;
        endcase
    end

    // Transaction sequencer. Reset abandons any in-flight transaction
    // without acknowledging it; a requester still holding req is simply
    // re-arbitrated afterwards. The pointer resets to NREQ-1 so requester 0
    // is first in line, and it moves to the winner only when the op commits.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_state  <= IDLE;
            r_rrPtr  <= IDXW'(NREQ - 1);
            r_winner <= '0;
            r_op     <= OP_LOAD;
            r_din    <= '0;
            r_out    <= '0;
            r_gnt    <= '0;
            r_ack    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_winner <= w_winner;
                        r_op     <= w_winnerOp;
                        r_din    <= w_winnerDin;
                        r_gnt    <= w_winnerOneHot;
                        r_state  <= GRANT;
                    end
                end
                GRANT: begin
                    r_out   <= w_nextOut;
                    r_ack   <= r_gnt;
                    r_rrPtr <= r_winner;
                    r_state <= COMMIT;
                end
                COMMIT: begin
                    r_gnt   <= '0;
                    r_ack   <= '0;
                    r_state <= IDLE;
                end
                default: begin
                    r_gnt   <= '0;
                    r_ack   <= '0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.gnt     = r_gnt;
    assign bus.ack     = r_ack;
    assign bus.out     = r_out;
    assign bus.out_bar = ~r_out;
    assign bus.busy    = (r_state != IDLE);

endmodule
